// File: rtl/rotate_rr_arbiter.sv
// rtl/rotate_rr_arbiter.sv - round-robin arbiter sharing one 8-bit rotator among N_REQ requesters

module barrel_shifter_multi_rev (
    input  logic [7:0] i_data,
    input  logic [2:0] i_amt,
    input  logic       i_dir,
    output logic [7:0] o_data
);

    // Bit k takes its source from k-amt (left) or k+amt (right); 3-bit index math wraps mod 8
    always_comb begin
        o_data = '0;
        for (int k = 0; k < 8; k++) begin
            if (i_dir) begin
                o_data[k] = i_data[3'(k) - i_amt];
            end else begin
                o_data[k] = i_data[3'(k) + i_amt];
            end
        end
    end

endmodule

module rotate_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [8*N_REQ-1:0]   req_data,
    input  logic [3*N_REQ-1:0]   req_amt,
    input  logic [N_REQ-1:0]     req_dir,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [7:0]           rsp_data,
    output logic [ID_W-1:0]      rsp_id,
    output logic [7:0]           rsp_count
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [ID_W-1:0]   r_last_grant;
    logic [7:0]        r_rsp_data;
    logic [ID_W-1:0]   r_rsp_id;
    logic [7:0]        r_rsp_count;

    logic [N_REQ-1:0]  w_grant;
    logic [ID_W-1:0]   w_grant_id;
    logic              w_found;
    logic              w_acc_en;
    logic              w_req_fire;
    logic              w_rsp_fire;

    logic [7:0]        w_rot_in;
    logic [2:0]        w_rot_amt;
    logic              w_rot_dir;
    logic [7:0]        w_rot_out;

    // Round-robin search starting just after the last winner; first valid requester wins
    always_comb begin
        w_grant    = '0;
        w_grant_id = '0;
        w_found    = 1'b0;
        for (int off = 1; off <= N_REQ; off++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!w_found && req_valid[i] &&
                    (i == ((int'(r_last_grant) + off) % N_REQ))) begin
                    w_found    = 1'b1;
                    w_grant[i] = 1'b1;
                    w_grant_id = ID_W'(i);
                end
            end
        end
    end

    // One-hot AND-OR mux steering the granted requester into the single shared rotator
    always_comb begin
        w_rot_in  = '0;
        w_rot_amt = '0;
        w_rot_dir = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant[i]) begin
                w_rot_in  = w_rot_in  | req_data[8*i +: 8];
                w_rot_amt = w_rot_amt | req_amt[3*i +: 3];
                w_rot_dir = w_rot_dir | req_dir[i];
            end
        end
    end

    barrel_shifter_multi_rev u_rotator (
        .i_data (w_rot_in),
        .i_amt  (w_rot_amt),
        .i_dir  (w_rot_dir),
        .o_data (w_rot_out)
    );

    // Output stage occupancy register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Output stage next state: fill on accept, empty only when draining without a reload
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_EMPTY: if (w_req_fire) w_state_next = ST_FULL;
            ST_FULL:  if (w_rsp_fire && !w_req_fire) w_state_next = ST_EMPTY;
            default:  w_state_next = ST_EMPTY;
        endcase
    end

    // Handshake outputs; req_ready is forced low while reset is asserted
    always_comb begin
        rsp_valid  = (r_state == ST_FULL);
        w_acc_en   = !rsp_valid || rsp_ready;
        req_ready  = rst_n ? (w_grant & {N_REQ{w_acc_en}}) : '0;
        w_req_fire = |(req_valid & req_ready);
        w_rsp_fire = rsp_valid && rsp_ready;
    end

    // Result, winner ID and pointer load only on a request handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_data   <= '0;
            r_rsp_id     <= '0;
            r_last_grant <= ID_W'(N_REQ - 1);
        end else if (w_req_fire) begin
            r_rsp_data   <= w_rot_out;
            r_rsp_id     <= w_grant_id;
            r_last_grant <= w_grant_id;
        end
    end

    // Completed-response counter, wraps naturally at 8 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_count <= '0;
        end else if (w_rsp_fire) begin
            r_rsp_count <= r_rsp_count + 8'd1;
        end
    end

    assign rsp_data  = r_rsp_data;
    assign rsp_id    = r_rsp_id;
    assign rsp_count = r_rsp_count;

endmodule
